codma_task_fetch: RTL and testbench
===================================

# codma_task_fetch

Descriptor fetch and sequencing front end of the codma engine. Given a task pointer, it reads the 16-byte task descriptor from memory and validates it. It hands a copy command to the data mover, follows type-2 link descriptors, and finally writes the 64-bit status word that software (and the bench's data checker) reads back. It sits between the host start interface and the copy/burst data mover, sharing the single memory port with it through an external arbiter.

## Interface
- MEM_BYTES, 256: addressable memory size in bytes (32 words x 8 bytes).
- LINK_DEPTH, 4: maximum descriptors processed per start, including the first.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- task_ptr_i  in  32  byte address of first descriptor, 8-byte aligned
- status_ptr_i  in  32  byte address of status word, 8-byte aligned
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write (status), 0 = read (descriptor)
- mem_addr_o  out  32  byte address
- mem_wdata_o  out  64  status write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  64  read data
- cmd_valid_o  out  1  copy command valid
- cmd_ready_i  in  1  data mover accepts command
- cmd_type_o  out  2  0 = 8-byte singles, 1 = 32-byte bursts
- cmd_src_o  out  32  source byte address
- cmd_dst_o  out  32  destination byte address
- cmd_len_o  out  32  length in bytes
- xfer_done_i  in  1  data mover finished command (pulse)
- xfer_err_i  in  1  qualifies xfer_done_i: transfer failed
- busy_o  out  1  high from start acceptance to done pulse
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  status of last run; held until next accepted start

## Operation
- Descriptor layout:
  - word0 = {source_addr[63:32], task_type[31:0]}.
  - word1 = {len_bytes[63:32], dest_addr[31:0]}.
  - The link descriptor of a type-2 task sits at descriptor address + 32.
- States: IDLE, RD0, RD0_W, RD1, RD1_W, CHECK, ISSUE, WAIT_XFER, STATUS, DONE.
- IDLE → RD0 on start_i.
  - Latch pointers; clear error_o; set link count to 1.
- RD0/RD1: assert mem_req_o (we = 0) at ptr / ptr+8 until mem_gnt_i, then go to *_W.
- *_W: capture mem_rdata_i on mem_rvalid_i.
  - RD0_W → RD1; RD1_W → CHECK.
- CHECK (one cycle): error if any of the following holds.
  - task_type > 2.
  - len = 0.
  - type 0 and len not a multiple of 8.
  - type 1/2 and len not a multiple of 32.
  - src+len > MEM_BYTES or dst+len > MEM_BYTES (33-bit sums, no wrap).
  - Type 2 and link count = LINK_DEPTH.
  - Error → STATUS with data 1; otherwise → ISSUE.
- ISSUE: drive cmd_valid_o with fields held stable until cmd_ready_i.
  - cmd_type_o = 0 for type 0, 1 for types 1 and 2.
  - Then → WAIT_XFER.
- WAIT_XFER on xfer_done_i:
  - If xfer_err_i: → STATUS with data 1.
  - Else if type 2: ptr += 32, increment link count, → RD0.
  - Else: → STATUS with data 0.
- STATUS: write request at status_ptr with mem_wdata_o = 0 or 1 and we = 1; on mem_gnt_i → DONE.
- DONE: pulse done_o, update error_o, → IDLE.
- start_i while busy is ignored.

## Timing
- Reset values:
  - State IDLE.
  - mem_req_o, mem_we_o, cmd_valid_o, busy_o, done_o, error_o = 0.
  - mem_addr_o, mem_wdata_o, cmd_* = 0.
- Outputs are registered.
- Start to first mem_req_o: 1 cycle.
- One outstanding memory access. mem_rvalid_i arrives ≥1 cycle after mem_gnt_i.
- Minimum latency, start to done_o, with zero-wait memory and mover: 9 cycles plus mover time.
- mem_gnt_i in the same cycle as request assertion is legal.
- cmd_ready_i may be high before cmd_valid_o; the handshake completes on the cycle both are high.
- xfer_done_i outside WAIT_XFER is ignored.
- mem_rvalid_i outside *_W is ignored.
- reset asserted in any state returns to IDLE next edge and drops all requests mid-handshake. No status write occurs.
- busy_o is low in the cycle done_o is high, so start is accepted the next cycle.

## Test plan
- Type 0: descriptor at 0x00 = {0x40,0}, {16,0x80}.
  - Reads at 0x00, 0x08; cmd type 0, src 0x40, dst 0x80, len 16.
  - After xfer_done_i: write 0 to 0xF8; done_o pulse; error_o = 0.
- Type 1: {0x20,1}, {64,0x60} → one cmd type 1, len 64; status 0.
- Type 2 link:
  - Descriptor at 0x00 = {0x40,2}, {32,0x80}; link at 0x20 = {0x10,0}, {8,0xC0}.
  - Reads at 0x00, 0x08, 0x20, 0x28; two cmds in order; status 0.
- Range error: {0xF0,0}, {32,0x00}.
  - No cmd_valid_o; status write 1; error_o = 1.
  - Repeat with type 3, and with type 1 len 24: same response.
- Mover error: xfer_err_i with xfer_done_i on a type-2 first task → link not fetched; status 1.
- Robustness:
  - Reset during WAIT_XFER → all outputs 0 next cycle; fresh start runs scenario 1 cleanly.
  - Stalled mem_gnt_i for 5 cycles keeps mem_req_o/mem_addr_o stable.
  - start_i while busy is ignored.

Source files
------------

// File: rtl/codma_task_fetch.sv
// codma_task_fetch: fetches and validates codma task descriptors, issues copy commands,
// follows type-2 links and writes the 64-bit status word
module codma_task_fetch #(
  parameter int MEM_BYTES  = 256,
  parameter int LINK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] task_ptr_i,
  input  logic [31:0] status_ptr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [1:0]  cmd_type_o,
  output logic [31:0] cmd_src_o,
  output logic [31:0] cmd_dst_o,
  output logic [31:0] cmd_len_o,
  input  logic        xfer_done_i,
  input  logic        xfer_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);
  localparam int LW = $clog2(LINK_DEPTH + 1);
  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);
  typedef enum logic [3:0] {IDLE, RD0, RD0_W, RD1, RD1_W, CHECK, ISSUE, WAIT_XFER, STATUS, DONE} state_t;
  state_t state, state_n;
  logic [31:0] ptr, ptr_n, sptr;
  logic [63:0] w0, w1;
  logic [LW-1:0] links, links_n;
  logic stat, stat_n, bad;
  logic [31:0] ttype, src, dst, len;
  assign ttype = w0[31:0];
  assign src   = w0[63:32];
  assign dst   = w1[31:0];
  assign len   = w1[63:32];
  // 33-bit sums so a descriptor reaching past the top of memory cannot wrap into range
  assign bad = ttype > 32'd2 || len == 32'd0 || (ttype == 32'd0 ? |len[2:0] : |len[4:0]) ||
               {1'b0, src} + {1'b0, len} > LIMIT || {1'b0, dst} + {1'b0, len} > LIMIT ||
               (ttype == 32'd2 && links == LW'(LINK_DEPTH));
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    links_n = links;
    stat_n  = stat;
    case (state)
      IDLE: if (start_i) begin
        state_n = RD0;
        ptr_n   = task_ptr_i;
        links_n = LW'(1);
        stat_n  = 1'b0;
      end
      RD0:   state_n = mem_gnt_i ? RD0_W : RD0;
      RD0_W: state_n = mem_rvalid_i ? RD1 : RD0_W;
      RD1:   state_n = mem_gnt_i ? RD1_W : RD1;
      RD1_W: state_n = mem_rvalid_i ? CHECK : RD1_W;
      CHECK: begin
        state_n = bad ? STATUS : ISSUE;
        stat_n  = bad;
      end
      ISSUE: state_n = cmd_ready_i ? WAIT_XFER : ISSUE;
      WAIT_XFER: if (xfer_done_i) begin
        if (!xfer_err_i && ttype == 32'd2) begin
          state_n = RD0;
          ptr_n   = ptr + 32'd32;
          links_n = links + LW'(1);
        end else begin
          state_n = STATUS;
          stat_n  = xfer_err_i;
        end
      end
      STATUS: state_n = mem_gnt_i ? DONE : STATUS;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next-state decode so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      sptr        <= '0;
      w0          <= '0;
      w1          <= '0;
      links       <= '0;
      stat        <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_src_o   <= '0;
      cmd_dst_o   <= '0;
      cmd_len_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      links       <= links_n;
      stat        <= stat_n;
      sptr        <= state == IDLE && start_i ? status_ptr_i : sptr;
      w0          <= state == RD0_W && mem_rvalid_i ? mem_rdata_i : w0;
      w1          <= state == RD1_W && mem_rvalid_i ? mem_rdata_i : w1;
      mem_req_o   <= state_n inside {RD0, RD1, STATUS};
      mem_we_o    <= state_n == STATUS;
      mem_addr_o  <= state_n == RD0 ? ptr_n : state_n == RD1 ? ptr + 32'd8 :
                     state_n == STATUS ? sptr : mem_addr_o;
      mem_wdata_o <= state_n == STATUS ? {63'd0, stat_n} : mem_wdata_o;
      cmd_valid_o <= state_n == ISSUE;
      cmd_type_o  <= state_n == ISSUE ? {1'b0, ttype != 32'd0} : cmd_type_o;
      cmd_src_o   <= state_n == ISSUE ? src : cmd_src_o;
      cmd_dst_o   <= state_n == ISSUE ? dst : cmd_dst_o;
      cmd_len_o   <= state_n == ISSUE ? len : cmd_len_o;
      busy_o      <= state_n != IDLE && state_n != DONE;
      done_o      <= state_n == DONE;
      error_o     <= state == IDLE && start_i ? 1'b0 : state_n == DONE ? stat_n : error_o;
    end
  end
endmodule

// File: tb/tb_codma_task_fetch.sv
// tb_codma_task_fetch: directed descriptor scenarios checked against a transaction-level model
module tb_codma_task_fetch;
  logic clk = 0, reset = 1, start_i = 0;
  logic [31:0] task_ptr_i = 0, status_ptr_i = 0;
  logic mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [63:0] mem_rdata_i = 0;
  logic cmd_valid_o, cmd_ready_i = 0;
  logic [1:0] cmd_type_o;
  logic [31:0] cmd_src_o, cmd_dst_o, cmd_len_o;
  logic xfer_done_i = 0, xfer_err_i = 0, busy_o, done_o, error_o;
  typedef struct packed {logic [31:0] addr; logic we; logic [63:0] wdata;} mem_t;
  typedef struct packed {logic [1:0] typ; logic [31:0] src; logic [31:0] dst; logic [31:0] len;} cmd_t;
  logic [63:0] mem [32];
  mem_t exp_mem[$];
  cmd_t exp_cmd[$];
  logic exp_err = 0;
  int tests = 0, fails = 0;
  int gnt_stall = 0, rdy_wait = 0, mv_delay = 1, ncmd = 0;
  bit mv_err_first = 0, done_seen = 0;
  bit rd_pend = 0, prev_wait = 0, prev_cv = 0, mv_err_now = 0;
  int scnt = 0, vcnt = 0, mv_cnt = 0;
  logic [31:0] rd_addr = 0, prev_addr = 0;
  cmd_t prev_cmd, cur_cmd;
  mem_t me;
  cmd_t mc;
  localparam logic [63:0] MARK = 64'hDEAD_BEEF_0000_0055;

  always #5 clk = ~clk;

  codma_task_fetch dut (
    .clk(clk), .reset(reset), .start_i(start_i), .task_ptr_i(task_ptr_i), .status_ptr_i(status_ptr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_type_o(cmd_type_o),
    .cmd_src_o(cmd_src_o), .cmd_dst_o(cmd_dst_o), .cmd_len_o(cmd_len_o),
    .xfer_done_i(xfer_done_i), .xfer_err_i(xfer_err_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Walks the descriptor chain in bench memory and lists every memory access, command and the final status
  task automatic build(input logic [31:0] tp);
    longint p, src, dst, len, typ, gran;
    int cnt, n;
    logic [63:0] w0, w1;
    p = tp; cnt = 1; n = 0;
    exp_mem.delete(); exp_cmd.delete(); exp_err = 0;
    forever begin
      exp_mem.push_back('{addr: 32'(p), we: 1'b0, wdata: 64'd0});
      exp_mem.push_back('{addr: 32'(p + 8), we: 1'b0, wdata: 64'd0});
      w0 = mem[int'(p / 8) % 32];
      w1 = mem[int'(p / 8 + 1) % 32];
      typ = w0[31:0]; src = w0[63:32]; dst = w1[31:0]; len = w1[63:32];
      gran = typ == 0 ? 8 : 32;
      if (typ > 2 || len == 0 || len % gran != 0 || src + len > 256 || dst + len > 256 || (typ == 2 && cnt == 4)) begin
        exp_err = 1;
        break;
      end
      exp_cmd.push_back('{typ: typ == 0 ? 2'd0 : 2'd1, src: 32'(src), dst: 32'(dst), len: 32'(len)});
      if (mv_err_first && n == 0) begin
        exp_err = 1;
        break;
      end
      n++;
      if (typ != 2) break;
      p += 32;
      cnt++;
    end
    exp_mem.push_back('{addr: 32'hF8, we: 1'b1, wdata: {63'd0, exp_err}});
  endtask

  // Memory, data mover and per-cycle checker, all on the falling edge
  initial forever begin
    @(negedge clk);
    if (reset) begin
      mem_gnt_i = 0; mem_rvalid_i = 0; cmd_ready_i = 0; xfer_done_i = 0; xfer_err_i = 0;
      rd_pend = 0; mv_cnt = 0; scnt = 0; vcnt = 0; prev_wait = 0; prev_cv = 0;
    end else begin
      mem_rvalid_i = rd_pend;
      if (rd_pend) mem_rdata_i = mem[rd_addr[7:3]];
      rd_pend = 0;
      if (prev_wait) begin
        chk("req_hold", mem_req_o, 1);
        chk("addr_hold", mem_addr_o, prev_addr);
      end
      mem_gnt_i = mem_req_o && scnt >= gnt_stall;
      scnt = (mem_req_o && !mem_gnt_i) ? scnt + 1 : 0;
      prev_wait = mem_req_o && !mem_gnt_i;
      prev_addr = mem_addr_o;
      if (mem_req_o && mem_gnt_i) begin
        if (exp_mem.size() == 0) chk("mem_extra", mem_req_o, 0);
        else begin
          me = exp_mem.pop_front();
          chk("mem_addr", mem_addr_o, me.addr);
          chk("mem_we", mem_we_o, me.we);
          if (me.we) chk("mem_wdata", mem_wdata_o, me.wdata);
        end
        if (mem_we_o) mem[mem_addr_o[7:3]] = mem_wdata_o;
        else begin
          rd_pend = 1;
          rd_addr = mem_addr_o;
        end
      end
      xfer_done_i = 0; xfer_err_i = 0;
      if (mv_cnt > 0) begin
        mv_cnt--;
        if (mv_cnt == 0) begin
          xfer_done_i = 1;
          xfer_err_i = mv_err_now;
        end
      end
      cur_cmd = {cmd_type_o, cmd_src_o, cmd_dst_o, cmd_len_o};
      if (prev_cv) begin
        chk("cmd_hold_v", cmd_valid_o, 1);
        chk("cmd_hold", cur_cmd == prev_cmd, 1);
      end
      cmd_ready_i = rdy_wait == 0 || (cmd_valid_o && vcnt >= rdy_wait);
      vcnt = (cmd_valid_o && !cmd_ready_i) ? vcnt + 1 : 0;
      prev_cv = cmd_valid_o && !cmd_ready_i;
      prev_cmd = cur_cmd;
      if (cmd_valid_o && cmd_ready_i) begin
        if (exp_cmd.size() == 0) chk("cmd_extra", cmd_valid_o, 0);
        else begin
          mc = exp_cmd.pop_front();
          chk("cmd_type", cmd_type_o, mc.typ);
          chk("cmd_src", cmd_src_o, mc.src);
          chk("cmd_dst", cmd_dst_o, mc.dst);
          chk("cmd_len", cmd_len_o, mc.len);
        end
        mv_cnt = mv_delay;
        mv_err_now = mv_err_first && ncmd == 0;
        ncmd++;
      end
      if (done_o) begin
        chk("done_busy", busy_o, 0);
        chk("done_err", error_o, exp_err);
        chk("mem_left", exp_mem.size(), 0);
        chk("cmd_left", exp_cmd.size(), 0);
        done_seen = 1;
      end
    end
  end

  task automatic clear_mem;
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
  endtask

  task automatic set_desc(input int a, input logic [31:0] src, input logic [31:0] typ,
                          input logic [31:0] len, input logic [31:0] dst);
    mem[a / 8] = {src, typ};
    mem[a / 8 + 1] = {len, dst};
  endtask

  task automatic kick(input logic [31:0] tp);
    mem[31] = MARK; ncmd = 0; done_seen = 0;
    task_ptr_i = tp; status_ptr_i = 32'hF8; start_i = 1;
    @(negedge clk);
    start_i = 0; task_ptr_i = 32'h40;
    chk("first_req", mem_req_o, 1);
    chk("busy_on", busy_o, 1);
    chk("err_clear", error_o, 0);
  endtask

  task automatic finish_run(input logic [63:0] stat);
    int i;
    i = 0;
    while (!done_seen && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", done_seen, 1);
    @(negedge clk);
    chk("status_word", mem[31], stat);
    chk("err_held", error_o, stat[0]);
    chk("busy_off", busy_o, 0);
  endtask

  initial begin
    int i;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_ctl", {mem_req_o, mem_we_o, cmd_valid_o, busy_o, done_o, error_o, cmd_type_o}, 0);
    chk("rst_addr", {mem_addr_o, cmd_len_o}, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_cmd", {cmd_src_o, cmd_dst_o}, 0);
    reset = 0;
    @(negedge clk);
    // type 0 single descriptor
    set_desc(0, 32'h40, 0, 16, 32'h80);
    build(0);
    chk("m1_nmem", exp_mem.size(), 3);
    chk("m1_cmd", exp_cmd[0] == cmd_t'{2'd0, 32'h40, 32'h80, 32'd16}, 1);
    kick(0);
    finish_run(0);
    // type 1 with a stalled grant
    clear_mem(); gnt_stall = 5;
    set_desc(0, 32'h20, 1, 64, 32'h60);
    build(0);
    chk("m2_cmd", exp_cmd[0] == cmd_t'{2'd1, 32'h20, 32'h60, 32'd64}, 1);
    kick(0);
    finish_run(0);
    gnt_stall = 0;
    // type 2 link, slow ready and mover, start while busy
    clear_mem(); rdy_wait = 3; mv_delay = 3;
    set_desc(0, 32'h40, 2, 32, 32'h80);
    set_desc(32'h20, 32'h10, 0, 8, 32'hC0);
    build(0);
    chk("m3_nmem", exp_mem.size(), 5);
    chk("m3_link_addr", exp_mem[2].addr, 32'h20);
    chk("m3_cmd1", exp_cmd[1] == cmd_t'{2'd0, 32'h10, 32'hC0, 32'd8}, 1);
    kick(0);
    repeat (3) @(negedge clk);
    task_ptr_i = 32'h40; start_i = 1;
    @(negedge clk);
    start_i = 0;
    finish_run(0);
    rdy_wait = 0; mv_delay = 1;
    // range error
    clear_mem();
    set_desc(0, 32'hF0, 0, 32, 32'h00);
    build(0);
    chk("m4_err", exp_err, 1);
    chk("m4_ncmd", exp_cmd.size(), 0);
    kick(0);
    finish_run(1);
    // bad type
    set_desc(0, 32'h00, 3, 8, 32'h00);
    build(0);
    chk("m5_err", exp_err, 1);
    kick(0);
    finish_run(1);
    // type 1 length not a burst multiple
    set_desc(0, 32'h00, 1, 24, 32'h00);
    build(0);
    kick(0);
    finish_run(1);
    // exactly reaching the top of memory is legal
    set_desc(0, 32'hE0, 1, 32, 32'hE0);
    build(0);
    chk("m7_err", exp_err, 0);
    kick(0);
    finish_run(0);
    // link depth exhausted on the fourth type-2 descriptor
    clear_mem();
    for (int k = 0; k < 4; k++) set_desc(k * 32, 32'h00, 2, 32, 32'h80);
    build(0);
    chk("m8_ncmd", exp_cmd.size(), 3);
    chk("m8_nmem", exp_mem.size(), 9);
    kick(0);
    finish_run(1);
    // mover error on the first of a linked pair
    clear_mem(); mv_err_first = 1;
    set_desc(0, 32'h40, 2, 32, 32'h80);
    set_desc(32'h20, 32'h10, 0, 8, 32'hC0);
    build(0);
    chk("m9_nmem", exp_mem.size(), 3);
    kick(0);
    finish_run(1);
    mv_err_first = 0;
    // reset while waiting on the mover, then a clean rerun
    clear_mem(); mv_delay = 8;
    set_desc(0, 32'h40, 0, 16, 32'h80);
    build(0);
    kick(0);
    i = 0;
    while (ncmd == 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("rst_cmd_seen", ncmd, 1);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_ctl", {mem_req_o, mem_we_o, cmd_valid_o, busy_o, done_o, error_o, cmd_type_o}, 0);
    chk("rst_mid_bus", {mem_addr_o, cmd_len_o}, 0);
    chk("rst_mid_cmd", {cmd_src_o, cmd_dst_o}, 0);
    reset = 0;
    exp_mem.delete(); exp_cmd.delete(); mv_delay = 1;
    repeat (3) @(negedge clk);
    chk("rst_no_status", mem[31], MARK);
    build(0);
    kick(0);
    finish_run(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
